// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 keyboard event controller:
//   - kbd_state_e : byte-assembly FSM states
//   - PS2_PFX_*   : prefix bytes that start multi-byte sequences
//   - PAUSE_SKIP  : number of bytes that follow E1 in the Pause sequence
//   - EV_*        : event word layout ({ext, brk, code})
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } kbd_state_e;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int EV_W   = 10;
    localparam int EV_EXT = 9;
    localparam int EV_BRK = 8;

    function automatic logic [EV_W-1:0] make_event(input logic ext, input logic brk,
                                                   input logic [7:0] code);
        logic [EV_W-1:0] ev;
        ev         = {2'b00, code};
        ev[EV_EXT] = ext;
        ev[EV_BRK] = brk;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
// Synchronous FIFO holding keyboard events; head is shown combinationally
// (0 when empty) so a pushed entry appears one cycle after the push.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (empties FIFO)
//   push, push_data    : write request and data
//   pop                : read request (ignored when empty)
//   head               : oldest entry, 0 when empty
//   full, empty, count : occupancy status
// A push into a full FIFO is accepted only if a pop happens in the same
// cycle, which frees the slot being written.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
        // Power-of-two depth: pointers wrap by natural overflow.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
// Turns raw PS/2 scan-code bytes into keyboard events (make/break,
// standard/extended, Pause), queues them for the CPU and raises a level
// interrupt while events are pending.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rx_valid, rx_data   : byte from the decoder, taken on rx_valid 0->1
//   ev_data             : FIFO head {ext, brk, code}, 0 when empty
//   ev_empty, ev_count  : FIFO status
//   ev_rd               : pop one event per cycle high
//   irq_en, irq         : interrupt enable / level interrupt
//   ovf, seq_err        : sticky overflow / sequence-timeout flags
//   err_clr             : clears the sticky flags (a same-cycle set wins)
//   ps2_clk_inhibit     : PS/2 clock pull-low request
// Build option: define PS2_INHIBIT_EN to hold the keyboard off while the
// FIFO is nearly full; otherwise ps2_clk_inhibit is tied low.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CNT_W          = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic [EV_W-1:0]               ev_data,
    output logic                          ev_empty,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    input  logic                          ev_rd,
    input  logic                          irq_en,
    output logic                          irq,
    output logic                          ovf,
    output logic                          seq_err,
    input  logic                          err_clr,
    output logic                          ps2_clk_inhibit
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    kbd_state_e       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             rx_valid_q;
    logic             ovf_q, ovf_d;
    logic             seq_err_q, seq_err_d;
    logic             byte_stb;
    logic             timeout;
    logic             push;
    logic [EV_W-1:0]  push_data;
    logic             fifo_full;

    always_comb begin
        byte_stb  = rx_valid & ~rx_valid_q;
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = '0;
        push      = 1'b0;
        push_data = '0;
        timeout   = 1'b0;

        if (state_q != IDLE) begin
            tmo_d = tmo_q + CNT_W'(1);
        end

        if (byte_stb) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data == PS2_PFX_EXT) begin
                        state_d = EXT;
                    end else if (rx_data == PS2_PFX_BRK) begin
                        state_d = BRK;
                    end else if (rx_data == PS2_PFX_PAUSE) begin
                        state_d = PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        push      = 1'b1;
                        push_data = make_event(1'b0, 1'b0, rx_data);
                    end
                end
                EXT: begin
                    if (rx_data == PS2_PFX_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        push      = 1'b1;
                        push_data = make_event(1'b1, 1'b0, rx_data);
                        state_d   = IDLE;
                    end
                end
                BRK: begin
                    push      = 1'b1;
                    push_data = make_event(1'b0, 1'b1, rx_data);
                    state_d   = IDLE;
                end
                EXT_BRK: begin
                    push      = 1'b1;
                    push_data = make_event(1'b1, 1'b1, rx_data);
                    state_d   = IDLE;
                end
                PAUSE: begin
                    // Every byte after E1 is swallowed; the last one emits
                    // the single Pause event.
                    if (skip_q == 3'd1) begin
                        push      = 1'b1;
                        push_data = make_event(1'b1, 1'b0, PS2_PFX_PAUSE);
                        state_d   = IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if ((state_q != IDLE) && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            // The counter would reach TIMEOUT_CYCLES this cycle.
            timeout = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
        end

        ovf_d     = (ovf_q & ~err_clr) | (push & fifo_full & ~ev_rd);
        seq_err_d = (seq_err_q & ~err_clr) | timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Preload the edge detector so a level already high is not a byte.
            rx_valid_q <= rx_valid;
            state_q    <= IDLE;
            skip_q     <= '0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            state_q    <= state_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            seq_err_q  <= seq_err_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (ev_rd),
        .head      (ev_data),
        .full      (fifo_full),
        .empty     (ev_empty),
        .count     (ev_count)
    );

    assign irq     = irq_en & ~ev_empty;
    assign ovf     = ovf_q;
    assign seq_err = seq_err_q;

`ifdef PS2_INHIBIT_EN
    assign ps2_clk_inhibit = (ev_count >= CW'(FIFO_DEPTH - 1)) && (state_q == IDLE);
`else
    assign ps2_clk_inhibit = 1'b0;
`endif

endmodule
